multi_seven_seg_scan: RTL
=========================

// Module: multi_seven_seg_scan
// PURPOSE
//   Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
//   Captures a packed hex value into a shadow register on a load strobe, then scans the digits one at a time.
//   Per-digit blanking, decimal points, leading-zero suppression and an anti-ghosting guard interval.
//   Sits between the datapath (value producer) and board pins; all outputs active-low.
// PARAMETERS
//   NUM_DIGITS  4  number of digits scanned (>=1)
//   DIV_WIDTH   5  slot length P = 2**DIV_WIDTH clk cycles per digit
//   GUARD       1  cycles at start of each slot with all anodes off (0 <= GUARD < P)
// PORTS
//   clk        in   1             system clock, rising edge
//   rst        in   1             synchronous reset, active-high
//   load       in   1             capture val/dp_in/blank into shadow regs this edge
//   val        in   4*NUM_DIGITS  packed nibbles, digit i = val[4i+3:4i], digit 0 rightmost
//   dp_in      in   NUM_DIGITS    1 = light decimal point of digit i
//   blank      in   NUM_DIGITS    1 = force digit i dark
//   lz_en      in   1             1 = suppress leading zeros (live, not shadowed)
//   an         out  NUM_DIGITS    anode enables, active-low, an[i] = digit i
//   seg        out  7             {ca,cb,cc,cd,ce,cf,cg}, active-low
//   dp         out  1             decimal point, active-low
//   digit_idx  out  max(1,clog2(NUM_DIGITS))  digit index of current slot
// BEHAVIOUR
//   Reset (rst=1 at edge): div=0, digit_idx=0, shadows=0, an=all 1, seg=7'h7F, dp=1. rst beats load.
//   Divider: div increments every cycle, wraps P-1 -> 0; on div==P-1 digit_idx increments,
//     NUM_DIGITS-1 wraps to 0 (non-power-of-2 counts must wrap, never index past last digit).
//   Shadow: on load=1 edge, sh_val/sh_dp/sh_blank <= val/dp_in/blank; otherwise held.
//     Inputs changing without load have no effect on display.
//   Outputs an/seg/dp are registered from current (div, digit_idx, shadows, lz_en): 1-cycle latency.
//   Digit d=digit_idx is dark (an all 1, seg=7'h7F, dp=1) when any of:
//     div < GUARD; sh_blank[d]=1; lz_en=1 and d!=0 and sh_val nibbles d..NUM_DIGITS-1 all zero.
//   Otherwise an[d]=0, other an bits 1, seg = decode(sh_val nibble d), dp = ~sh_dp[d].
//   Decode, {ca..cg}: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//     6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001
//     d=1000010 E=0110000 F=0111000.
//   Digit 0 is never leading-zero suppressed (value 0 shows "0").
//   Load mid-slot: new shadow shown from next output update; scan position unaffected.
//   At most one an bit low in any cycle; never glitches between slots (registered outputs).
//   Reset mid-scan: next cycle all dark, scan restarts at digit 0, div=0.
// TESTING  (bench: NUM_DIGITS=4, DIV_WIDTH=2 so P=4, GUARD=1)
//   Reset: rst=1 3 cycles -> an=4'b1111, seg=7'h7F, dp=1; after release an=4'b1110
//     for edges 2..4 after deassert, then 4'b1101, 4'b1011, 4'b0111, repeat.
//   load val=16'h1234, dp_in=4'b0010 -> slots show seg 1001100,0000110,0010010,1001111;
//     dp=0 only while an=4'b1101.
//   lz_en=1, load val=16'h0050 -> an never 4'b0111/4'b1011; digit1 seg=0100100, digit0 seg=0000001.
//   lz_en=1, load val=16'h0000 -> only an=4'b1110 ever asserted, seg=0000001; lz_en=0 -> all four show 0.
//   Change val to 16'hFFFF with load=0 -> display unchanged; pulse load -> every digit seg=0111000.
//   blank=4'b0100 loaded -> an=4'b1011 never seen, slot timing of others unchanged;
//     rst during digit-2 slot -> next cycle all dark, digit_idx=0.

Source files
------------

// File: rtl/multi_seven_seg_scan.sv
// multi_seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// 7-segment display. A packed hex value, decimal points and blank mask are
// captured into shadow registers on `load`. The digits are then scanned one
// slot at a time. Each slot lasts 2**DIV_WIDTH clocks, and its first GUARD
// clocks are dark so that the previous digit cannot ghost into the next one.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             capture val/dp_in/blank into the shadow registers
//   val              packed nibbles, digit i = val[4i+3:4i], digit 0 rightmost
//   dp_in, blank     per-digit decimal point / force-dark
//   lz_en            suppress leading zeros (live input, not shadowed)
//   an, seg, dp      active-low board outputs, registered
//   digit_idx        digit index of the current slot

// Per-digit lane: hex -> {ca..cg} active-low pattern, plus a zero flag that
// feeds the leading-zero chain.
module multi_seven_seg_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg7,
  output logic       is_zero
);
  always_comb begin
    unique case (nib)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
    is_zero = (nib == 4'h0);
  end
endmodule

module multi_seven_seg_scan #(
  parameter  int NUM_DIGITS = 4,
  parameter  int DIV_WIDTH  = 5,
  parameter  int GUARD      = 1,
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IW-1:0]           digit_idx
);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]           div;
  logic [NUM_DIGITS-1:0][3:0]     sh_val;
  logic [NUM_DIGITS-1:0]          sh_dp, sh_blank;

  logic [NUM_DIGITS-1:0][6:0]     lane_seg;
  logic [NUM_DIGITS-1:0]          lane_zero;
  // lead_zero[d]: nibbles d..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0]          lead_zero;
  logic                           guard_on, dark;
  logic [NUM_DIGITS-1:0]          an_nxt;
  logic [6:0]                     seg_nxt;
  logic                           dp_nxt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    multi_seven_seg_lane u_lane (
      .nib     (sh_val[g]),
      .seg7    (lane_seg[g]),
      .is_zero (lane_zero[g])
    );
  end

  if (GUARD == 0) begin : g_noguard
    assign guard_on = 1'b0;
  end else begin : g_guard
    assign guard_on = (div < DIV_WIDTH'(GUARD));
  end

  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = lane_zero[NUM_DIGITS-1];
    for (int d = NUM_DIGITS - 2; d >= 0; d--)
      lead_zero[d] = lane_zero[d] & lead_zero[d+1];
  end

  // Digit 0 is exempt from suppression, so a zero value still shows "0".
  always_comb begin
    dark    = guard_on | sh_blank[digit_idx] |
              (lz_en & (digit_idx != '0) & lead_zero[digit_idx]);
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!dark) begin
      an_nxt[digit_idx] = 1'b0;
      seg_nxt           = lane_seg[digit_idx];
      dp_nxt            = ~sh_dp[digit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      digit_idx <= '0;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      an        <= '1;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      div <= div + 1'b1;              // P is a power of two: wraps naturally
      if (&div)
        digit_idx <= (digit_idx == LAST) ? '0 : digit_idx + 1'b1;
      if (load) begin
        sh_val   <= val;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end
endmodule
